// File: rtl/imgproc_pkg.sv
// Shared constants and FSM state type for the image-processing message poller.
package imgproc_pkg;

  localparam logic [2:0]  REG_STATUS       = 3'd0;
  localparam logic [2:0]  READ_MSG         = 3'd1;
  localparam logic [2:0]  READ_ID          = 3'd2;
  localparam logic [2:0]  REG_BBCOL        = 3'd3;
  localparam int          STATUS_FLUSH_BIT = 4;
  localparam logic [31:0] MSG_ID_RBB       = 32'h0052_4242;
  localparam int          COORD_W          = 11;

  typedef enum logic [3:0] {
    INIT_COL,
    WAIT_TMR,
    RD_STAT,
    CAP_STAT,
    GAP0,
    RD_W0,
    CAP_W0,
    GAP1,
    RD_W1,
    CAP_W1,
    GAP2,
    RD_W2,
    CAP_W2,
    PUBLISH,
    FLUSH
  } state_e;

endpackage

// File: rtl/imgproc_bb_calc.sv
// Holds the published bounding box and derives centre, width and the empty-frame flag.
module imgproc_bb_calc
  import imgproc_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_i,
  input  logic [COORD_W-1:0] x_min_i,
  input  logic [COORD_W-1:0] y_min_i,
  input  logic [COORD_W-1:0] x_max_i,
  input  logic [COORD_W-1:0] y_max_i,
  output logic [COORD_W-1:0] x_min_o,
  output logic [COORD_W-1:0] y_min_o,
  output logic [COORD_W-1:0] x_max_o,
  output logic [COORD_W-1:0] y_max_o,
  output logic [COORD_W-1:0] cx_o,
  output logic [COORD_W-1:0] w_o,
  output logic               no_object_o
);

  logic [COORD_W:0]   sum_d;
  logic [COORD_W-1:0] cx_d;
  logic [COORD_W-1:0] w_d;
  logic               no_obj_d;

  // Centre uses a one-bit-wider sum so the carry is not lost before halving.
  always_comb begin
    sum_d    = {1'b0, x_min_i} + {1'b0, x_max_i};
    cx_d     = sum_d[COORD_W:1];
    no_obj_d = (x_min_i > x_max_i);
    w_d      = no_obj_d ? '0 : (x_max_i - x_min_i + 11'd1);
  end

  // Outputs only change on load, so they hold across flushes and idle polls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_min_o     <= '0;
      y_min_o     <= '0;
      x_max_o     <= '0;
      y_max_o     <= '0;
      cx_o        <= '0;
      w_o         <= '0;
      no_object_o <= 1'b0;
    end else if (load_i) begin
      x_min_o     <= x_min_i;
      y_min_o     <= y_min_i;
      x_max_o     <= x_max_i;
      y_max_o     <= y_max_i;
      cx_o        <= cx_d;
      w_o         <= w_d;
      no_object_o <= no_obj_d;
    end
  end

endmodule

// File: rtl/imgproc_msg_poller.sv
// Avalon-MM master: sets the box colour, polls STATUS and drains one RBB message per poll.
//
// state    | meaning
// INIT_COL | write box colour to REG_BBCOL (waits one cycle after reset release)
// WAIT_TMR | poll interval timer; holds at terminal count while enable=0
// RD_STAT  | read strobe, STATUS
// CAP_STAT | capture usedw; need >=3 words to read a message
// GAPn     | idle cycle so the FIFO never sees back-to-back reads
// RD_Wn    | read strobe, READ_MSG word n
// CAP_Wn   | capture word n (ID / top-left / bottom-right)
// PUBLISH  | bb_valid pulse, calc outputs already loaded
// FLUSH    | write flush bit to STATUS after an ID mismatch
module imgproc_msg_poller
  import imgproc_pkg::*;
#(
  parameter int          POLL_INTERVAL = 1000,
  parameter logic [31:0] MSG_ID        = MSG_ID_RBB,
  parameter logic [23:0] BB_COL_INIT   = 24'h00ff00
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  output logic                m_chipselect,
  output logic                m_read,
  output logic                m_write,
  output logic [2:0]          m_address,
  output logic [31:0]         m_writedata,
  input  logic [31:0]         m_readdata,
  output logic                bb_valid,
  output logic [COORD_W-1:0]  bb_x_min,
  output logic [COORD_W-1:0]  bb_y_min,
  output logic [COORD_W-1:0]  bb_x_max,
  output logic [COORD_W-1:0]  bb_y_max,
  output logic [COORD_W-1:0]  bb_cx,
  output logic [COORD_W-1:0]  bb_w,
  output logic                no_object,
  output logic [7:0]          sync_err_cnt,
  output logic                busy
);

  localparam int              TW       = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [TW-1:0]   TMR_LAST = TW'(POLL_INTERVAL - 1);

  state_e             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               started_q;
  logic [COORD_W-1:0] x_min_q, x_min_d;
  logic [COORD_W-1:0] y_min_q, y_min_d;
  logic [7:0]         err_q, err_d;
  logic               calc_load;

  // State, timer and captured top-left corner; started_q keeps strobes low while in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= INIT_COL;
      timer_q   <= '0;
      started_q <= 1'b0;
      x_min_q   <= '0;
      y_min_q   <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      started_q <= 1'b1;
      x_min_q   <= x_min_d;
      y_min_q   <= y_min_d;
      err_q     <= err_d;
    end
  end

  // Next-state and bus strobes decoded from the current state.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    x_min_d     = x_min_q;
    y_min_d     = y_min_q;
    err_d       = err_q;
    calc_load   = 1'b0;
    m_read      = 1'b0;
    m_write     = 1'b0;
    m_address   = REG_STATUS;
    m_writedata = '0;
    bb_valid    = 1'b0;
    unique case (state_q)
      INIT_COL: begin
        if (started_q) begin
          m_write     = 1'b1;
          m_address   = REG_BBCOL;
          m_writedata = {8'h00, BB_COL_INIT};
          state_d     = WAIT_TMR;
        end
      end
      WAIT_TMR: begin
        if (timer_q == TMR_LAST) begin
          if (enable) begin
            timer_d = '0;
            state_d = RD_STAT;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RD_STAT: begin
        m_read    = 1'b1;
        m_address = REG_STATUS;
        state_d   = CAP_STAT;
      end
      CAP_STAT: state_d = (m_readdata[15:8] >= 8'd3) ? GAP0 : WAIT_TMR;
      GAP0:     state_d = RD_W0;
      RD_W0: begin
        m_read    = 1'b1;
        m_address = READ_MSG;
        state_d   = CAP_W0;
      end
      CAP_W0: begin
        if (m_readdata != MSG_ID) begin
          state_d = FLUSH;
          if (err_q != 8'hff) err_d = err_q + 8'd1;
        end else begin
          state_d = GAP1;
        end
      end
      GAP1:     state_d = RD_W1;
      RD_W1: begin
        m_read    = 1'b1;
        m_address = READ_MSG;
        state_d   = CAP_W1;
      end
      CAP_W1: begin
        x_min_d = m_readdata[26:16];
        y_min_d = m_readdata[10:0];
        state_d = GAP2;
      end
      GAP2:     state_d = RD_W2;
      RD_W2: begin
        m_read    = 1'b1;
        m_address = READ_MSG;
        state_d   = CAP_W2;
      end
      CAP_W2: begin
        calc_load = 1'b1;
        state_d   = PUBLISH;
      end
      PUBLISH: begin
        bb_valid = 1'b1;
        state_d  = WAIT_TMR;
      end
      FLUSH: begin
        m_write     = 1'b1;
        m_address   = REG_STATUS;
        m_writedata = 32'(1) << STATUS_FLUSH_BIT;
        state_d     = WAIT_TMR;
      end
      default: state_d = INIT_COL;
    endcase
    m_chipselect = m_read | m_write;
  end

  assign busy         = started_q && (state_q != WAIT_TMR);
  assign sync_err_cnt = err_q;

  imgproc_bb_calc u_calc (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_i      (calc_load),
    .x_min_i     (x_min_q),
    .y_min_i     (y_min_q),
    .x_max_i     (m_readdata[26:16]),
    .y_max_i     (m_readdata[10:0]),
    .x_min_o     (bb_x_min),
    .y_min_o     (bb_y_min),
    .x_max_o     (bb_x_max),
    .y_max_o     (bb_y_max),
    .cx_o        (bb_cx),
    .w_o         (bb_w),
    .no_object_o (no_object)
  );

endmodule
